// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic-array activation path.
//   DefDataWidth   : default signed activation element width
//   DefRows        : default array rows (one skew lane per row)
//   act_vec_t      : one activation vector, element r in slice [r]
//   feeder_state_e : activation feeder control states
// -----------------------------------------------------------------------------
package sa_pkg;

   localparam int unsigned DefDataWidth = 8;
   localparam int unsigned DefRows      = 4;

   typedef logic [DefRows-1:0][DefDataWidth-1:0] act_vec_t;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } feeder_state_e;

endpackage

// File: rtl/sa_act_feeder_if.sv
// -----------------------------------------------------------------------------
// sa_act_feeder_if
// Valid/ready vector-input bus of the activation feeder. Signal suffixes are
// named from the feeder's point of view.
//   in_valid_i : vector offered
//   in_ready_o : feeder can accept the vector
//   in_data_i  : packed vector, element r in [DATA_WIDTH*(r+1)-1 -: DATA_WIDTH]
//   in_last_i  : vector is the last of its tile
// Modports: master = upstream producer, slave = feeder.
// -----------------------------------------------------------------------------
interface sa_act_feeder_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ROWS       = 4
);

   logic                       in_valid_i;
   logic                       in_ready_o;
   logic [DATA_WIDTH*ROWS-1:0] in_data_i;
   logic                       in_last_i;

   modport master (
      output in_valid_i,
      output in_data_i,
      output in_last_i,
      input  in_ready_o
   );

   modport slave (
      input  in_valid_i,
      input  in_data_i,
      input  in_last_i,
      output in_ready_o
   );

endinterface

// File: rtl/sa_sync_fifo.sv
// -----------------------------------------------------------------------------
// sa_sync_fifo
// Single-clock FIFO, first-word fall-through read (rdata_o shows the head
// entry whenever empty_o is low). Synchronous active-low reset empties it.
//   clk, rstn : clock, synchronous active-low reset
//   push_i    : write wdata_i (ignored when full)
//   wdata_i   : write data
//   pop_i     : drop the head entry (ignored when empty)
//   rdata_o   : head entry
//   full_o    : DEPTH entries held
//   empty_o   : no entries held
// -----------------------------------------------------------------------------
module sa_sync_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PtrW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_d = count_q + (PtrW+1)'(1);
      else if (!do_push && do_pop) count_d = count_q - (PtrW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; emptiness is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/sa_act_feeder.sv
// -----------------------------------------------------------------------------
// sa_act_feeder
// Buffers whole activation vectors and feeds them to the 4x4 systolic array as
// diagonally skewed per-row streams (row r lags row 0 by r cycles). Injects
// zero bubbles when the buffer runs dry mid-tile, and flushes the array with
// 2*ROWS-1 zero vectors after the last vector of a tile.
//   clk, rstn        : clock, synchronous active-low reset
//   in_if            : vector input bus (valid/ready/data/last), slave side
//   data_a_0_o..3_o  : skewed lane outputs to array rows 0..3
//   acc_en_o         : accumulate enable, high while lanes carry tile data
//   busy_o           : controller not idle
//   done_o           : one-cycle pulse when a tile's drain completes
// The four lane ports tie this block to ROWS = 4.
// -----------------------------------------------------------------------------
module sa_act_feeder
   import sa_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned ROWS       = DefRows,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   sa_act_feeder_if.slave        in_if,
   output logic [DATA_WIDTH-1:0] data_a_0_o,
   output logic [DATA_WIDTH-1:0] data_a_1_o,
   output logic [DATA_WIDTH-1:0] data_a_2_o,
   output logic [DATA_WIDTH-1:0] data_a_3_o,
   output logic                  acc_en_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int unsigned VecW        = DATA_WIDTH * ROWS;
   localparam int unsigned DrainCycles = 2 * ROWS - 1;
   localparam int unsigned CntW        = $clog2(DrainCycles + 1);
   localparam logic [CntW-1:0] DrainLast = CntW'(DrainCycles - 1);

   feeder_state_e   state_q, state_d;
   logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
   logic            done_q, done_d;
   logic            acc_en_q;
   logic            rst_done_q;

   logic            in_ready;
   logic            fifo_full, fifo_empty, fifo_pop;
   logic [VecW:0]   fifo_rdata;
   logic [VecW-1:0] inject;

   // Held low until the first clock edge after reset release.
   assign in_ready        = rst_done_q & ~fifo_full;
   assign in_if.in_ready_o = in_ready;

   sa_sync_fifo #(
      .WIDTH (VecW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (in_if.in_valid_i & in_ready),
      .wdata_i ({in_if.in_last_i, in_if.in_data_i}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      done_d      = 1'b0;
      fifo_pop    = 1'b0;
      inject      = '0;
      unique case (state_q)
         IDLE: begin
            // No pop on this transition: STREAM starts popping next cycle.
            if (!fifo_empty) state_d = STREAM;
         end
         STREAM: begin
            // Empty FIFO leaves inject at zero: a bubble that is MAC-neutral.
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               inject   = fifo_rdata[VecW-1:0];
               if (fifo_rdata[VecW]) begin
                  state_d     = DRAIN;
                  drain_cnt_d = '0;
               end
            end
         end
         DRAIN: begin
            if (drain_cnt_q == DrainLast) begin
               state_d     = IDLE;
               drain_cnt_d = '0;
               done_d      = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + CntW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         drain_cnt_q <= '0;
         done_q      <= 1'b0;
         acc_en_q    <= 1'b0;
         rst_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         done_q      <= done_d;
         // Every non-idle cycle injects into lane 0, visible one cycle later.
         acc_en_q    <= (state_q != IDLE);
         rst_done_q  <= 1'b1;
      end
   end

   // Lane r is r+1 registers deep, giving element r a latency of r+1 cycles.
   logic [DATA_WIDTH-1:0] lane_out [ROWS];

   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      logic [DATA_WIDTH-1:0] stage_q [r+1];

      always_ff @(posedge clk) begin
         if (!rstn) begin
            for (int s = 0; s <= r; s++) stage_q[s] <= '0;
         end else begin
            stage_q[0] <= inject[r*DATA_WIDTH +: DATA_WIDTH];
            for (int s = 1; s <= r; s++) stage_q[s] <= stage_q[s-1];
         end
      end

      assign lane_out[r] = stage_q[r];
   end

   assign data_a_0_o = lane_out[0];
   assign data_a_1_o = lane_out[1];
   assign data_a_2_o = lane_out[2];
   assign data_a_3_o = lane_out[3];
   assign acc_en_o   = acc_en_q;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;

endmodule

// File: tb/tb_sa_act_feeder.sv
// -----------------------------------------------------------------------------
// tb_sa_act_feeder
// Directed bench for sa_act_feeder. Each scenario fills per-cycle tables
// (offered vector, injected vector, expected acc_en/busy/done/ready, reset),
// then run_sched drives the inputs and checks every output each cycle.
// Lane expectations: a vector injected at cycle s shows element r on lane r
// at cycle s+1+r, unless a reset edge falls in between.
// -----------------------------------------------------------------------------
module tb_sa_act_feeder;
   import sa_pkg::*;

   localparam int NC = 32;

   logic       clk;
   logic       rstn;
   logic [7:0] lane_o [4];
   logic       acc_en, busy, done;

   int n_cmp = 0;
   int n_err = 0;

   act_vec_t vecs [8];
   logic     vlast [8];
   int       offer [NC];
   int       inj [NC];
   logic     rst_tab [NC];
   logic     acc_tab [NC];
   logic     busy_tab [NC];
   logic     done_tab [NC];
   logic     rdy_tab [NC];

   sa_act_feeder_if #(.DATA_WIDTH(8), .ROWS(4)) in_if ();

   sa_act_feeder #(
      .DATA_WIDTH (8),
      .ROWS       (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_if      (in_if),
      .data_a_0_o (lane_o[0]),
      .data_a_1_o (lane_o[1]),
      .data_a_2_o (lane_o[2]),
      .data_a_3_o (lane_o[3]),
      .acc_en_o   (acc_en),
      .busy_o     (busy),
      .done_o     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string tag, input int c, input logic [7:0] obs,
                       input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input int c, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, c, obs, exp);
      end
   endtask

   task automatic clear_tabs();
      for (int c = 0; c < NC; c++) begin
         offer[c]    = -1;
         inj[c]      = -1;
         rst_tab[c]  = 1'b1;
         acc_tab[c]  = 1'b0;
         busy_tab[c] = 1'b0;
         done_tab[c] = 1'b0;
         rdy_tab[c]  = 1'b1;
      end
      for (int i = 0; i < 8; i++) vlast[i] = 1'b0;
   endtask

   // which: 0 acc_en high, 1 busy high, 2 done high, 3 ready low
   task automatic mark(input int which, input int lo, input int hi);
      for (int c = lo; c <= hi; c++) begin
         case (which)
            0:       acc_tab[c]  = 1'b1;
            1:       busy_tab[c] = 1'b1;
            2:       done_tab[c] = 1'b1;
            default: rdy_tab[c]  = 1'b0;
         endcase
      end
   endtask

   function automatic logic [7:0] lane_exp(input int c, input int r);
      int s;
      s = c - 1 - r;
      if (s < 0) return 8'h00;
      if (inj[s] < 0) return 8'h00;
      for (int j = s; j < c; j++) if (!rst_tab[j]) return 8'h00;
      return vecs[inj[s]][r];
   endfunction

   task automatic idle_inputs();
      in_if.in_valid_i = 1'b0;
      in_if.in_data_i  = '0;
      in_if.in_last_i  = 1'b0;
   endtask

   task automatic run_sched(input string tag, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         rstn = rst_tab[c];
         if (offer[c] >= 0) begin
            in_if.in_valid_i = 1'b1;
            in_if.in_data_i  = vecs[offer[c]];
            in_if.in_last_i  = vlast[offer[c]];
         end else begin
            idle_inputs();
         end
         for (int r = 0; r < 4; r++)
            chk8($sformatf("%s lane%0d", tag, r), c, lane_o[r], lane_exp(c, r));
         chk1({tag, " acc_en"}, c, acc_en, acc_tab[c]);
         chk1({tag, " busy"}, c, busy, busy_tab[c]);
         chk1({tag, " done"}, c, done, done_tab[c]);
         chk1({tag, " ready"}, c, in_if.in_ready_o, rdy_tab[c]);
         tick();
      end
      idle_inputs();
      rstn = 1'b1;
   endtask

   // One vector with last=1 offered at c0: pop c2, drain c3..9, done c10.
   task automatic setup_single(input act_vec_t v);
      clear_tabs();
      vecs[0]  = v;
      vlast[0] = 1'b1;
      offer[0] = 0;
      inj[2]   = 0;
      mark(0, 3, 10);
      mark(1, 2, 9);
      mark(2, 10, 10);
   endtask

   task automatic load_rowmajor(input int base);
      for (int i = 0; i < 4; i++)
         for (int r = 0; r < 4; r++) vecs[i][r] = 8'(base + 4 * i + r + 1);
   endtask

   initial begin
      rstn = 1'b0;
      idle_inputs();

      // Reset values.
      tick();
      tick();
      for (int r = 0; r < 4; r++) chk8($sformatf("rst lane%0d", r), 0, lane_o[r], 8'h00);
      chk1("rst acc_en", 0, acc_en, 1'b0);
      chk1("rst busy", 0, busy, 1'b0);
      chk1("rst done", 0, done, 1'b0);
      chk1("rst ready", 0, in_if.in_ready_o, 1'b0);
      rstn = 1'b1;
      tick();
      chk1("rel ready", 0, in_if.in_ready_o, 1'b1);
      chk1("rel busy", 0, busy, 1'b0);

      // Single vector {4,3,2,1}.
      setup_single({8'd4, 8'd3, 8'd2, 8'd1});
      run_sched("single", 13);

      // Four-vector tile 1..16, valid held high: pops c2..5, drain c6..12.
      clear_tabs();
      load_rowmajor(0);
      vlast[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         offer[i]   = i;
         inj[i + 2] = i;
      end
      mark(0, 3, 13);
      mark(1, 2, 12);
      mark(2, 13, 13);
      run_sched("tile4", 18);

      // Upstream stall: valid low c2..5, pop slots c4..6 find the FIFO empty.
      clear_tabs();
      load_rowmajor(16);
      vlast[3] = 1'b1;
      offer[0] = 0;
      offer[1] = 1;
      offer[6] = 2;
      offer[7] = 3;
      inj[2]   = 0;
      inj[3]   = 1;
      inj[7]   = 2;
      inj[8]   = 3;
      mark(0, 3, 16);
      mark(1, 2, 15);
      mark(2, 16, 16);
      run_sched("stall", 20);

      // Fill FIFO during the previous tile's drain; 5th offer held while full.
      clear_tabs();
      for (int i = 0; i < 6; i++)
         for (int r = 0; r < 4; r++) vecs[i][r] = 8'(40 + 10 * i + r);
      vlast[0] = 1'b1;
      vlast[5] = 1'b1;
      offer[0] = 0;
      for (int i = 1; i <= 4; i++) offer[i + 2] = i;
      for (int c = 7; c <= 12; c++) offer[c] = 5;
      inj[2] = 0;
      for (int i = 1; i <= 5; i++) inj[i + 10] = i;
      mark(3, 7, 11);
      mark(0, 3, 10);
      mark(0, 12, 23);
      mark(1, 2, 9);
      mark(1, 11, 22);
      mark(2, 10, 10);
      mark(2, 23, 23);
      run_sched("full", 26);

      // Extreme signed values pass through unchanged.
      setup_single({8'h80, 8'hFF, 8'h7F, 8'h80});
      run_sched("signed", 13);

      // One-cycle reset at c4 mid-STREAM: everything zero from c5, no done.
      clear_tabs();
      load_rowmajor(0);
      vlast[3] = 1'b1;
      for (int i = 0; i < 4; i++) offer[i] = i;
      inj[2]     = 0;
      inj[3]     = 1;
      inj[4]     = 2;
      rst_tab[4] = 1'b0;
      mark(0, 3, 4);
      mark(1, 2, 4);
      mark(3, 5, 5);
      run_sched("midrst", 15);

      // New tile after the mid-tile reset.
      setup_single({8'd4, 8'd3, 8'd2, 8'd1});
      run_sched("post_rst", 13);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
